// File: rtl/delay_credit_fifo.sv
// delay_credit_fifo
// Receive-side buffer for a non-stallable fixed-latency pipeline. A credit
// counter gates issue so every item in flight owns a slot when it arrives.
// The head word is held in a register so o_valid/o_data are flop outputs.
module delay_credit_fifo #(
    parameter int WID   = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     iss_v,
    output logic                     iss_rdy,
    input  logic                     arr_v,
    input  logic [WID-1:0]           arr_d,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [WID-1:0]           o_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   credits,
    output logic                     ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WID-1:0] mem_q [DEPTH];

    logic [CW-1:0]  credits_q, credits_d;
    logic [CW-1:0]  count_q,   count_d;
    logic [PW-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q,  rd_ptr_d;
    logic           o_valid_q, o_valid_d;
    logic [WID-1:0] o_data_q,  o_data_d;
    logic           ovf_q,     ovf_d;

    logic issue;
    logic pop;
    logic wr_en;
    logic drop;

    // Next-state: credit accounting, occupancy, pointers and the head word.
    always_comb begin
        issue = iss_v & ce & (credits_q != '0);
        pop   = o_valid_q & o_ready;
        // A same-cycle pop frees the slot, so a full FIFO can still accept.
        wr_en = arr_v & ((count_q != FULL) | pop);
        drop  = arr_v & ~wr_en;

        credits_d = credits_q;
        unique case ({issue, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = (credits_q == FULL) ? credits_q : credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase

        count_d = count_q;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        ovf_d    = ovf_q | drop;

        o_valid_d = (count_d != '0);
        // The next head is the word being written now whenever the read
        // pointer lands on the write slot (empty, or count 1 with pop).
        o_data_d = o_data_q;
        if (count_d != '0) begin
            if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
                o_data_d = arr_d;
            end else begin
                o_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Control and head registers; reset wins over any same-cycle activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= FULL;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage array; contents need no reset since count qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= arr_d;
        end
    end

    assign iss_rdy = (credits_q != '0);
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign count   = count_q;
    assign credits = credits_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_delay_credit_fifo.sv
// Scoreboard bench for delay_credit_fifo: a behavioural model tracks
// occupancy, credits and expected data order; a negedge monitor compares.
module tb_delay_credit_fifo;

    localparam int WID   = 8;
    localparam int DEPTH = 8;
    localparam int DEP   = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ce = 1'b0;
    logic           iss_v = 1'b0;
    logic           iss_rdy;
    logic           arr_v = 1'b0;
    logic [WID-1:0] arr_d = '0;
    logic           o_valid;
    logic           o_ready = 1'b0;
    logic [WID-1:0] o_data;
    logic [3:0]     count;
    logic [3:0]     credits;
    logic           ovf;

    delay_credit_fifo #(.WID(WID), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ce(ce), .iss_v(iss_v), .iss_rdy(iss_rdy),
        .arr_v(arr_v), .arr_d(arr_d), .o_valid(o_valid), .o_ready(o_ready),
        .o_data(o_data), .count(count), .credits(credits), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    int             m_cnt = 0;
    int             m_cred = DEPTH;
    int             in_flight = 0;
    bit             m_ovf = 0;
    bit             inv_en = 0;
    bit             stream = 0;
    bit             mon_en = 0;
    logic [WID-1:0] exp_q[$];
    logic [WID-1:0] last_out = '0;
    bit             pipe_v[DEP];
    logic [WID-1:0] pipe_d[DEP];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: update the model with the inputs applied at this edge.
    task automatic tick();
        bit iss, pp, wr;
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_cred = DEPTH; m_ovf = 0; in_flight = 0;
            exp_q.delete();
            for (int i = 0; i < DEP; i++) begin pipe_v[i] = 0; pipe_d[i] = '0; end
        end else begin
            iss = iss_v && ce && (m_cred > 0);
            pp  = o_ready && (m_cnt > 0);
            wr  = arr_v && ((m_cnt < DEPTH) || pp);
            m_cred = m_cred + int'(pp) - int'(iss);
            if (m_cred > DEPTH) m_cred = DEPTH;
            m_cnt = m_cnt + int'(wr) - int'(pp);
            if (wr) exp_q.push_back(arr_d);
            if (arr_v && !wr) m_ovf = 1;
            if (inv_en) in_flight = in_flight + int'(iss) - int'(arr_v);
            if (stream) begin
                for (int i = DEP - 1; i > 0; i--) begin
                    pipe_v[i] = pipe_v[i-1];
                    pipe_d[i] = pipe_d[i-1];
                end
                pipe_v[0] = iss;
                pipe_d[0] = WID'($urandom);
            end
        end
        #1;
        if (stream) begin
            arr_v = pipe_v[DEP-1];
            arr_d = pipe_d[DEP-1];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        o_ready = 1'b1;
        for (int k = 0; k < budget && m_cnt != 0; k++) tick();
        chk("drain_done", m_cnt, 0);
        o_ready = 1'b0;
        tick();
    endtask

    // Monitor: compare outputs to the model; pop expected data on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", count, m_cnt);
            chk("credits", credits, m_cred);
            chk("ovf", ovf, m_ovf);
            chk("iss_rdy", iss_rdy, m_cred != 0);
            chk("o_valid", o_valid, m_cnt != 0);
            if (inv_en) chk("invariant", int'(credits) + int'(count) + in_flight, DEPTH);
            if (m_cnt != 0 && exp_q.size() != 0) begin
                chk("o_data", o_data, exp_q[0]);
                if (o_ready) last_out = exp_q.pop_front();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        mon_en = 1;
        // reset state
        chk("rst_iss_rdy", iss_rdy, 1);
        chk("rst_credits", credits, 8);
        chk("rst_count", count, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_o_data", o_data, 0);

        // credit exhaustion
        inv_en = 1; ce = 1; iss_v = 1;
        for (int i = 0; i < 8; i++) tick();
        chk("exh_credits", credits, 0);
        chk("exh_iss_rdy", iss_rdy, 0);
        tick();
        chk("ninth_credits", credits, 0);
        iss_v = 0;
        for (int i = 0; i < 8; i++) begin
            arr_v = 1; arr_d = WID'(8'h10 + i);
            tick();
        end
        arr_v = 0;
        tick();
        chk("exh_count", count, 8);
        chk("exh_ovf", ovf, 0);
        drain(40);
        chk("exh_last", last_out, 8'h17);
        chk("exh_cred_back", credits, 8);
        inv_en = 0;

        // ce gating
        ce = 0; iss_v = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("ce_credits", credits, 8);
        arr_v = 1; arr_d = 8'h31; tick();
        arr_d = 8'h32; tick();
        arr_v = 0; iss_v = 0; tick();
        chk("ce_count", count, 2);
        drain(20);
        chk("ce_last", last_out, 8'h32);
        do_reset();

        // overflow
        for (int i = 0; i < 9; i++) begin
            arr_v = 1; arr_d = WID'(8'h40 + i);
            tick();
        end
        arr_v = 0;
        tick();
        chk("ovf_count", count, 8);
        chk("ovf_set", ovf, 1);
        drain(40);
        chk("ovf_last", last_out, 8'h47);
        chk("ovf_sticky", ovf, 1);
        do_reset();
        chk("ovf_cleared", ovf, 0);

        // full boundary with simultaneous pop and arrival
        for (int i = 0; i < 8; i++) begin
            arr_v = 1; arr_d = WID'(8'h50 + i);
            tick();
        end
        arr_v = 1; arr_d = 8'hAA; o_ready = 1;
        tick();
        arr_v = 0; o_ready = 0;
        chk("fb_count", count, 8);
        chk("fb_ovf", ovf, 0);
        drain(40);
        chk("fb_last", last_out, 8'hAA);
        do_reset();

        // streaming through a DEP-cycle pipeline model
        inv_en = 1; stream = 1; ce = 1; iss_v = 1;
        for (int i = 0; i < 200; i++) begin
            o_ready = 1'($urandom_range(0, 1));
            tick();
        end
        iss_v = 0; o_ready = 1;
        for (int i = 0; i < DEP + 2; i++) tick();
        drain(40);
        stream = 0; arr_v = 0;
        chk("st_ovf", ovf, 0);
        chk("st_credits", credits, 8);
        chk("st_inflight", in_flight, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/delay_credit_fifo.md
# delay_credit_fifo

Receive-side companion to the fixed-latency delay pipelines: captures results emerging from a non-stallable pipeline of any depth and presents them to a consumer with a valid/ready handshake. A credit counter gates issue into the pipeline, so every item in flight is guaranteed a FIFO slot on arrival. It sits between the pipeline output and any back-pressuring sink.

## Interface
- WID, 8: data width in bits.
- DEPTH, 8: FIFO entries and total credits. Power of two, at least 2.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  pipeline clock enable. Gates issue accounting only.
- iss_v  input  1  upstream requests to issue one item into the pipeline.
- iss_rdy  output  1  credit available: credits != 0. Driven directly from the credit register.
- arr_v  input  1  item arriving from the pipeline output.
- arr_d  input  WID  arriving data.
- o_valid  output  1  FIFO head valid.
- o_ready  input  1  consumer accepts the head.
- o_data  output  WID  FIFO head data.
- count  output  $clog2(DEPTH)+1  stored entries, 0..DEPTH.
- credits  output  $clog2(DEPTH)+1  free credits, 0..DEPTH.
- ovf  output  1  sticky error flag: an arrival hit a full FIFO.

## Operation
- Reset is synchronous, active-high, and overrides all other activity in that cycle, including in-flight bookkeeping. After reset:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - credits = DEPTH.
  - o_valid = 0, o_data = 0, ovf = 0.
- Items already in the pipeline at reset are the upstream's responsibility to flush.
- Issue: issue = iss_v & ce & iss_rdy. Each issue decrements credits by 1.
- iss_v without ce, or iss_v while credits = 0, has no effect.
- Pop: pop = o_valid & o_ready. Each pop returns 1 credit and removes the head.
- If issue and pop occur in the same cycle, credits is unchanged.
- Credits never exceed DEPTH and never underflow.
- Arrival: when arr_v = 1 and count < DEPTH (after counting a same-cycle pop), arr_d is written at wr_ptr and wr_ptr increments.
- Arrival is independent of ce.
- Arrival when full with no pop in that cycle:
  - data is dropped;
  - wr_ptr and count are unchanged;
  - ovf is set and stays set until rst.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- count changes as follows: +1 on write without pop, -1 on pop without write, unchanged when both or neither occur.
- Invariant: credits + count + in_flight = DEPTH, where in_flight = issues not yet arrived. A bench scoreboard checks this.
- Pop while o_valid = 0 is ignored.
- Data order is strict FIFO.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Issue seen at edge N: credits reflects it after N; iss_rdy follows in the same cycle as credits.
- Write-to-head latency is 1 cycle. An arrival into an empty FIFO at edge N gives o_valid = 1 and o_data = arr_d after edge N.
- Pop at edge N: the next entry, if any, appears on o_data after edge N, with o_valid held high. If the FIFO became empty, o_valid = 0 after N.
- Simultaneous pop and arrival with count = DEPTH is legal:
  - the head leaves and the arrival is stored;
  - count stays DEPTH;
  - ovf is not set.
- Simultaneous pop and arrival with count = 1: o_valid stays 1 and o_data becomes the arrived word after the edge.
- Full-rate sustained issue/arrive/pop is supported with o_ready held high. Throughput is 1 item per clock once the pipeline fills.
- o_data holds its value while o_valid = 1 and o_ready = 0.
- o_data is don't-care when o_valid = 0, but holds its last value.

## Test plan
- Reset: after rst, check iss_rdy = 1, credits = 8, count = 0, o_valid = 0, ovf = 0.
- Credit exhaustion: with o_ready = 0, issue 8 times with ce = 1 -> credits = 0, iss_rdy = 0. A 9th iss_v is ignored and credits stays 0. Deliver 8 arrivals 0x10..0x17 -> count = 8, ovf = 0. Then set o_ready = 1 -> data 0x10..0x17 pops in order, and credits returns to 8.
- ce gating: iss_v = 1 with ce = 0 for 5 cycles -> credits stays 8. Arrivals with ce = 0 are still stored.
- Overflow: force 9 arrivals with no pops -> the 9th is dropped, count = 8, ovf = 1. ovf stays 1 after draining and clears only on rst.
- Full-boundary simultaneity: count = 8, arrival 0xAA with pop in the same cycle -> count stays 8, ovf = 0, and 0xAA is the last item out.
- Streaming with a DEP = 5 delay pipeline model: issue every cycle for 200 cycles, with o_ready random at 50% -> no ovf, order preserved, and credits + count + in_flight = 8 every cycle.
